// File: rtl/sram_mem_arbiter.sv
// ============================================================================
// Module   : sram_mem_arbiter
// Purpose  : Merges the core's instruction and data SRAM-like ports onto one
//            shared memory req/resp bus, one outstanding transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit DATA_PRIO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [3:0]            inst_wstrb,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [31:0]           inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [31:0]           inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [3:0]            data_wstrb,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [31:0]           data_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [3:0]            mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, next_state;
  logic                  r_src_data;
  logic                  r_wr;
  logic [3:0]            r_wstrb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic grant_data, grant_inst, accept;

  // A lone requester always wins; DATA_PRIO only breaks ties.
  assign grant_data = data_req & (DATA_PRIO | ~inst_req);
  assign grant_inst = inst_req & ~grant_data;
  assign accept     = (state == IDLE) & (grant_data | grant_inst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_src_data <= 1'b0;
      r_wr       <= 1'b0;
      r_wstrb    <= 4'b0;
      r_addr     <= '0;
      r_wdata    <= 32'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        r_src_data <= grant_data;
        r_wr       <= grant_data ? data_wr    : inst_wr;
        r_wstrb    <= grant_data ? data_wstrb : inst_wstrb;
        r_addr     <= grant_data ? data_addr  : inst_addr;
        r_wdata    <= grant_data ? data_wdata : inst_wdata;
      end
    end
  end

  // Outputs are gated with rst so they read zero for the whole reset pulse,
  // including the asynchronous window before the next clock edge.
  always_comb begin
    next_state    = state;
    inst_addr_ok  = 1'b0;
    data_addr_ok  = 1'b0;
    inst_data_ok  = 1'b0;
    data_data_ok  = 1'b0;
    inst_rdata    = 32'b0;
    data_rdata    = 32'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 4'b0;
    mem_req_addr  = '0;
    mem_req_wdata = 32'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          inst_addr_ok = grant_inst;
          data_addr_ok = grant_data;
          if (grant_inst || grant_data) next_state = REQ;
        end
        REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = r_wr ? r_wstrb : 4'b0;
          mem_req_addr  = r_addr;
          mem_req_wdata = r_wdata;
          if (mem_req_ready) next_state = RESP;
        end
        RESP: begin
          if (mem_resp_valid) begin
            next_state = IDLE;
            if (r_src_data) begin
              data_data_ok = 1'b1;
              data_rdata   = r_wr ? 32'b0 : mem_resp_rdata;
            end else begin
              inst_data_ok = 1'b1;
              inst_rdata   = r_wr ? 32'b0 : mem_resp_rdata;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_arbiter.sv
// ============================================================================
// Module   : tb_sram_mem_arbiter
// Purpose  : Directed self-checking bench; u_dut uses DATA_PRIO=1, u_dut0 uses
//            DATA_PRIO=0 and shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req_valid;
  logic [31:0] inst_rdata, data_rdata, mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_we;

  logic        inst_addr_ok0, inst_data_ok0, data_addr_ok0, data_data_ok0, mem_req_valid0;
  logic [31:0] inst_rdata0, data_rdata0, mem_req_addr0, mem_req_wdata0;
  logic [3:0]  mem_req_we0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sram_mem_arbiter #(.ADDR_WIDTH(32), .DATA_PRIO(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  sram_mem_arbiter #(.ADDR_WIDTH(32), .DATA_PRIO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok0), .inst_data_ok(inst_data_ok0), .inst_rdata(inst_rdata0),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok0), .data_data_ok(data_data_ok0), .data_rdata(data_rdata0),
    .mem_req_valid(mem_req_valid0), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we0),
    .mem_req_addr(mem_req_addr0), .mem_req_wdata(mem_req_wdata0),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_wstrb = 4'h0;
    inst_addr = 32'h1C00_0000; inst_wdata = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0000_1000; data_wdata = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;

    // Reset: requests held high must not produce any output
    sample();
    chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    rst = 1'b0;

    // 1: single instruction read
    tick();
    inst_req = 1'b1; mem_req_ready = 1'b1;
    sample();
    chk("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
    chk("t1_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    tick();
    inst_req = 1'b0;
    sample();
    chk("t1_mem_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("t1_mem_addr", mem_req_addr, 32'h1C00_0000);
    chk("t1_mem_we", {28'b0, mem_req_we}, 32'd0);
    chk("t1_early_data_ok", {31'b0, inst_data_ok}, 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0280_0C0C;
    sample();
    chk("t1_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("t1_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("t1_mem_valid_resp", {31'b0, mem_req_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    chk("t1_data_ok_pulse", {31'b0, inst_data_ok}, 32'd0);

    // 2: simultaneous requests, data wins with DATA_PRIO=1
    pulse_reset();
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h0000_1000; data_wr = 1'b0;
    sample();
    chk("t2_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b0;
    sample();
    chk("t2_mem_addr_data", mem_req_addr, 32'h0000_1000);
    chk("t2_inst_wait", {31'b0, inst_addr_ok}, 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1122_3344;
    sample();
    chk("t2_data_data_ok", {31'b0, data_data_ok}, 32'd1);
    chk("t2_data_rdata", data_rdata, 32'h1122_3344);
    chk("t2_inst_rdata_zero", inst_rdata, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    chk("t2_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0;
    sample();
    chk("t2_mem_addr_inst", mem_req_addr, 32'h1C00_0000);
    chk("t2_mem_valid_inst", {31'b0, mem_req_valid}, 32'd1);

    // 3: data write with stalled memory
    pulse_reset();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_2004; data_wdata = 32'hDEAD_BEEF; mem_req_ready = 1'b0;
    sample();
    chk("t3_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; data_wstrb = 4'hF; data_addr = 32'hFFFF_FFF0; data_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_req_ready = 1'b1;
      sample();
      chk("t3_hold_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("t3_hold_we", {28'b0, mem_req_we}, 32'h3);
      chk("t3_hold_addr", mem_req_addr, 32'h0000_2004);
      chk("t3_hold_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    sample();
    chk("t3_data_data_ok", {31'b0, data_data_ok}, 32'd1);
    chk("t3_data_rdata_zero", data_rdata, 32'd0);
    tick();
    mem_resp_valid = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;

    // 4: reset while waiting for the response
    pulse_reset();
    inst_req = 1'b1; mem_req_ready = 1'b1;
    tick();
    inst_req = 1'b0;
    tick();
    sample();
    chk("t4_in_resp", {31'b0, mem_req_valid}, 32'd0);
    rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    #1;
    chk("t4_rst_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("t4_rst_rdata", inst_rdata, 32'd0);
    tick();
    rst = 1'b0;
    sample();
    chk("t4_late_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("t4_late_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("t4_late_mem_valid", {31'b0, mem_req_valid}, 32'd0);

    // 5: stray response in IDLE
    tick();
    sample();
    chk("t5_no_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("t5_no_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    tick();
    mem_resp_valid = 1'b0; data_req = 1'b1;
    sample();
    chk("t5_still_idle", {31'b0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0;

    // 6: simultaneous requests on the DATA_PRIO=0 instance
    pulse_reset();
    inst_req = 1'b1; data_req = 1'b1; mem_req_ready = 1'b1;
    inst_addr = 32'h1C00_0040; data_addr = 32'h0000_3000;
    sample();
    chk("t6_inst_addr_ok", {31'b0, inst_addr_ok0}, 32'd1);
    chk("t6_data_addr_ok", {31'b0, data_addr_ok0}, 32'd0);
    tick();
    inst_req = 1'b0;
    sample();
    chk("t6_mem_addr_inst", mem_req_addr0, 32'h1C00_0040);
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
    sample();
    chk("t6_inst_data_ok", {31'b0, inst_data_ok0}, 32'd1);
    chk("t6_inst_rdata", inst_rdata0, 32'h5555_AAAA);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    chk("t6_data_addr_ok_next", {31'b0, data_addr_ok0}, 32'd1);
    tick();
    data_req = 1'b0;
    sample();
    chk("t6_mem_addr_data", mem_req_addr0, 32'h0000_3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
